// File: rtl/stereolbm_axis_cambm_mul_pipe_rs.sv
// Pipelined multiplier for the stereo LBM cost/disparity datapath: exact product with
// per-operand signedness, optional rounding right-shift, saturate-or-wrap with overflow flag.
module stereolbm_axis_cambm_mul_pipe_rs #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 32,
  parameter int din1_WIDTH  = 34,
  parameter int dout_WIDTH  = 65,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  vld_in,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  vld_out,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  // P holds any product exactly; R adds the headroom for the rounding add.
  localparam int P = din0_WIDTH + din1_WIDTH + 1;
  localparam int R = P + 1;
  localparam int Q = ((R > dout_WIDTH) ? R : dout_WIDTH) + 2;

  localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  localparam logic signed [R-1:0] HALF =
    (SHIFT == 0) ? '0 : (R'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));

  // Result range limits, held in a width that can represent both r and the dout range.
  localparam logic signed [Q-1:0] RMAX = RES_SIGNED ?
    (Q'(1) << (dout_WIDTH - 1)) - Q'(1) : (Q'(1) << dout_WIDTH) - Q'(1);
  localparam logic signed [Q-1:0] RMIN = RES_SIGNED ?
    Q'(0) - (Q'(1) << (dout_WIDTH - 1)) : Q'(0);

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
    $error("NUM_STAGE must be in 1..8");
  end
  if (SHIFT < 0 || SHIFT > din0_WIDTH + din1_WIDTH - 1) begin : g_bad_shift
    $error("SHIFT must be in 0..din0_WIDTH+din1_WIDTH-1");
  end

  function automatic logic signed [P-1:0] mul_ext(input logic [din0_WIDTH-1:0] a,
                                                  input logic [din1_WIDTH-1:0] b);
    logic signed [P-1:0] ea;
    logic signed [P-1:0] eb;
    if (DIN0_SIGNED != 0) ea = P'($signed(a));
    else                  ea = P'(a);
    if (DIN1_SIGNED != 0) eb = P'($signed(b));
    else                  eb = P'(b);
    return ea * eb;
  endfunction

  // Round half toward +infinity by adding half an LSB before the arithmetic shift.
  function automatic logic signed [R-1:0] round_shift(input logic signed [P-1:0] p);
    logic signed [R-1:0] s;
    s = R'(p) + HALF;
    return s >>> SHIFT;
  endfunction

  // Returns {ovf, dout}.
  function automatic logic [dout_WIDTH:0] saturate(input logic signed [R-1:0] r);
    logic signed [Q-1:0]   rq;
    logic [dout_WIDTH-1:0] d;
    logic                  hi;
    logic                  lo;
    rq = Q'(r);
    hi = rq > RMAX;
    lo = rq < RMIN;
    d  = rq[dout_WIDTH-1:0];
    if (SATURATE != 0 && hi)      d = RMAX[dout_WIDTH-1:0];
    else if (SATURATE != 0 && lo) d = RMIN[dout_WIDTH-1:0];
    return {hi | lo, d};
  endfunction

  if (NUM_STAGE == 1) begin : g_one
    // Single stage: multiply, round and saturate feed the output register directly.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_out <= 1'b0;
        dout    <= '0;
        ovf     <= 1'b0;
      end else if (ce) begin
        vld_out     <= vld_in;
        {ovf, dout} <= saturate(round_shift(mul_ext(din0, din1)));
      end
    end
  end else begin : g_multi
    logic signed [P-1:0] prod_p [NUM_STAGE-1];
    logic [NUM_STAGE-2:0] vld_p;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) prod_p[i] <= '0;
        vld_p   <= '0;
        vld_out <= 1'b0;
        dout    <= '0;
        ovf     <= 1'b0;
      end else if (ce) begin
        // Stage 1: exact product
        prod_p[0] <= mul_ext(din0, din1);
        vld_p[0]  <= vld_in;
        // Stages 2..NUM_STAGE-1: pure delay
        for (int i = 1; i < NUM_STAGE - 1; i++) begin
          prod_p[i] <= prod_p[i-1];
          vld_p[i]  <= vld_p[i-1];
        end
        // Final stage: round, range-limit, register outputs
        vld_out     <= vld_p[NUM_STAGE-2];
        {ovf, dout} <= saturate(round_shift(prod_p[NUM_STAGE-2]));
      end
    end
  end

endmodule
